// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy VGA core: game-phase encoding, pipe count
// and default geometry used by the scroller, height table and renderer.
package flappy_pkg;

  localparam int NUM_PIPES   = 5;
  localparam int DEF_SPACING = 160;
  localparam int DEF_X_BASE  = 160;

  // One-hot so each Q_* output is a flop bit rather than a decode.
  typedef enum logic [2:0] {
    ST_INITIAL = 3'b001,
    ST_COUNT   = 3'b010,
    ST_STOP    = 3'b100
  } game_state_e;

  function automatic logic [2:0] mod5_next(input logic [2:0] v);
    return (v >= 3'(NUM_PIPES - 1)) ? 3'd0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Game-control bundle between the frame/collision sources and the pipe scroller.
interface pipe_scroller_if;

  logic       frame_tick;
  logic       Start;
  logic       collide;
  logic [2:0] I;
  logic [2:0] IC;
  logic       Q_Initial;
  logic       Q_Count;
  logic       Q_Stop;
  logic [9:0] XEdge0;
  logic [9:0] XEdge1;
  logic [9:0] XEdge2;
  logic [9:0] XEdge3;
  logic [9:0] XEdge4;
  logic       pass_pulse;
  logic [9:0] score;

  modport master (
    output frame_tick, Start, collide,
    input  I, IC, Q_Initial, Q_Count, Q_Stop,
    input  XEdge0, XEdge1, XEdge2, XEdge3, XEdge4,
    input  pass_pulse, score
  );

  modport slave (
    input  frame_tick, Start, collide,
    output I, IC, Q_Initial, Q_Count, Q_Stop,
    output XEdge0, XEdge1, XEdge2, XEdge3, XEdge4,
    output pass_pulse, score
  );

endinterface

// File: rtl/mod5_counter.sv
// Modulo-5 index counter used for the pipe index and the coin index.
module mod5_counter
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] out
);

  logic [2:0] out_d;
  logic [2:0] out_q;

  // NOTE: out_d is given its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_d = out_q;
    if (clr) begin
      out_d = 3'd0;
    end else if (inc) begin
      out_d = mod5_next(out_q);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= 3'd0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/pipe_scroller.sv
// Per-frame scroll offset, pipe/coin index rotation, score and game-phase FSM
// for the Flappy VGA core.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int SPACING    = DEF_SPACING,
  parameter int X_BASE     = DEF_X_BASE,
  parameter int SPEED_MIN  = 1,
  parameter int SPEED_MAX  = 4,
  parameter int RAMP_SHIFT = 3
) (
  input  logic           clk,
  input  logic           reset,
  pipe_scroller_if.slave bus
);

  localparam logic [8:0]  SPACING_V   = 9'(SPACING);
  localparam logic [8:0]  HALF_V      = 9'(SPACING / 2);
  localparam logic [10:0] SPEED_MIN_V = 11'(SPEED_MIN);
  localparam logic [10:0] SPEED_MAX_V = 11'(SPEED_MAX);

  game_state_e state_d, state_q;
  logic        start_prev_q;
  logic [7:0]  off_d, off_q;
  logic [9:0]  score_d, score_q;
  logic        pass_d, pass_q;
  logic [9:0]  xedge_d [NUM_PIPES];
  logic [9:0]  xedge_q [NUM_PIPES];

  logic        start_rise;
  logic        advance;
  logic        clr_idx;
  logic        pipe_wrap;
  logic        coin_wrap;
  logic [10:0] speed_full;
  logic [8:0]  speed;
  logic [8:0]  sum;
  logic [2:0]  pipe_idx;
  logic [2:0]  coin_idx;

  function automatic logic [9:0] xedge_at(input int k, input logic [7:0] off);
    return 10'(X_BASE + k * SPACING) - {2'b00, off};
  endfunction

  // Each Start transition needs a fresh rising edge, so a held Start cannot chain.
  assign start_rise = bus.Start & ~start_prev_q;

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    score_d   = score_q;
    pass_d    = 1'b0;
    advance   = 1'b0;
    clr_idx   = 1'b0;
    pipe_wrap = 1'b0;
    coin_wrap = 1'b0;

    speed_full = SPEED_MIN_V + {1'b0, (score_q >> RAMP_SHIFT)};
    speed      = (speed_full > SPEED_MAX_V) ? 9'(SPEED_MAX) : 9'(speed_full);
    sum        = {1'b0, off_q} + speed;

    case (state_q)
      ST_INITIAL: if (start_rise) state_d = ST_COUNT;
      ST_COUNT: begin
        // Collision wins over a coincident frame tick: stop without advancing.
        if (bus.collide)         state_d = ST_STOP;
        else if (bus.frame_tick) advance = 1'b1;
      end
      ST_STOP: begin
        if (start_rise) begin
          state_d = ST_INITIAL;
          clr_idx = 1'b1;
        end
      end
      default: begin
        state_d = ST_INITIAL;
        clr_idx = 1'b1;
      end
    endcase

    if (clr_idx) begin
      off_d   = 8'd0;
      score_d = 10'd0;
    end else if (advance) begin
      if (sum >= SPACING_V) begin
        off_d     = 8'(sum - SPACING_V);
        pipe_wrap = 1'b1;
        pass_d    = 1'b1;
        if (score_q != 10'h3FF) score_d = score_q + 10'd1;
      end else begin
        off_d     = sum[7:0];
        coin_wrap = ({1'b0, off_q} < HALF_V) && (sum >= HALF_V);
      end
    end

    for (int k = 0; k < NUM_PIPES; k++) begin
      xedge_d[k] = xedge_at(k, off_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INITIAL;
      start_prev_q <= 1'b0;
      off_q        <= 8'd0;
      score_q      <= 10'd0;
      pass_q       <= 1'b0;
      // NOTE: the edge array is plain register state, so every entry is reset like any other flop.
      for (int k = 0; k < NUM_PIPES; k++) begin
        xedge_q[k] <= xedge_at(k, 8'd0);
      end
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.Start;
      off_q        <= off_d;
      score_q      <= score_d;
      pass_q       <= pass_d;
      for (int k = 0; k < NUM_PIPES; k++) begin
        xedge_q[k] <= xedge_d[k];
      end
    end
  end

  mod5_counter u_pipe_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_idx),
    .inc   (pipe_wrap),
    .out   (pipe_idx)
  );

  mod5_counter u_coin_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_idx),
    .inc   (coin_wrap),
    .out   (coin_idx)
  );

  assign bus.I          = pipe_idx;
  assign bus.IC         = coin_idx;
  assign bus.Q_Initial  = state_q[0];
  assign bus.Q_Count    = state_q[1];
  assign bus.Q_Stop     = state_q[2];
  assign bus.XEdge0     = xedge_q[0];
  assign bus.XEdge1     = xedge_q[1];
  assign bus.XEdge2     = xedge_q[2];
  assign bus.XEdge3     = xedge_q[3];
  assign bus.XEdge4     = xedge_q[4];
  assign bus.pass_pulse = pass_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: directed game scenarios followed by
// random stimulus, all compared against a behavioural model of the game rules.
module tb_pipe_scroller;

  localparam int SPACING    = 160;
  localparam int X_BASE     = 160;
  localparam int SPEED_MIN  = 1;
  localparam int SPEED_MAX  = 4;
  localparam int RAMP_SHIFT = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_scroller_if bus ();

  pipe_scroller #(
    .SPACING    (SPACING),
    .X_BASE     (X_BASE),
    .SPEED_MIN  (SPEED_MIN),
    .SPEED_MAX  (SPEED_MAX),
    .RAMP_SHIFT (RAMP_SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: game phase 0=initial, 1=count, 2=stop.
  int m_state, m_off, m_i, m_ic, m_score;
  bit m_pass, m_prev_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_off   = 0;
    m_i     = 0;
    m_ic    = 0;
    m_score = 0;
  endtask

  task automatic model_edge();
    bit rise;
    int speed, sum;
    if (reset) begin
      m_state      = 0;
      m_pass       = 0;
      m_prev_start = 0;
      model_clear();
      return;
    end
    rise   = bus.Start && !m_prev_start;
    m_pass = 0;
    case (m_state)
      0: if (rise) m_state = 1;
      1: begin
        if (bus.collide) m_state = 2;
        else if (bus.frame_tick) begin
          speed = SPEED_MIN + m_score / (1 << RAMP_SHIFT);
          if (speed > SPEED_MAX) speed = SPEED_MAX;
          sum = m_off + speed;
          if (sum >= SPACING) begin
            m_off  = sum - SPACING;
            m_i    = (m_i + 1) % 5;
            m_pass = 1;
            if (m_score < 1023) m_score = m_score + 1;
          end else begin
            if (m_off < SPACING / 2 && sum >= SPACING / 2) m_ic = (m_ic + 1) % 5;
            m_off = sum;
          end
        end
      end
      default: begin
        if (rise) begin
          m_state = 0;
          model_clear();
        end
      end
    endcase
    m_prev_start = bus.Start;
  endtask

  function automatic logic [9:0] got_xedge(input int k);
    case (k)
      0:       return bus.XEdge0;
      1:       return bus.XEdge1;
      2:       return bus.XEdge2;
      3:       return bus.XEdge3;
      default: return bus.XEdge4;
    endcase
  endfunction

  task automatic check_all();
    check("Q_Initial", 32'(bus.Q_Initial), 32'(m_state == 0));
    check("Q_Count", 32'(bus.Q_Count), 32'(m_state == 1));
    check("Q_Stop", 32'(bus.Q_Stop), 32'(m_state == 2));
    check("I", 32'(bus.I), m_i);
    check("IC", 32'(bus.IC), m_ic);
    check("score", 32'(bus.score), m_score);
    check("pass_pulse", 32'(bus.pass_pulse), 32'(m_pass));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("XEdge%0d", k), 32'(got_xedge(k)), X_BASE + k * SPACING - m_off);
    end
  endtask

  // Inputs are stable across the edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  initial begin
    int budget;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.Start      = 1'b0;
    bus.collide    = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_xedge0", 32'(bus.XEdge0), 160);
    check("rst_xedge4", 32'(bus.XEdge4), 800);

    // Idle in INITIAL: ticks are ignored.
    repeat (10) tick();
    check("idle_q_initial", 32'(bus.Q_Initial), 1);
    check("idle_xedge2", 32'(bus.XEdge2), 480);

    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    check("start_q_count", 32'(bus.Q_Count), 1);

    repeat (80) tick();
    check("t80_xedge0", 32'(bus.XEdge0), 80);
    check("t80_ic", 32'(bus.IC), 1);
    check("t80_i", 32'(bus.I), 0);

    repeat (79) tick();
    bus.frame_tick = 1'b1;
    step();
    check("wrap_pass_hi", 32'(bus.pass_pulse), 1);
    check("wrap_i", 32'(bus.I), 1);
    check("wrap_xedge0", 32'(bus.XEdge0), 160);
    check("wrap_score", 32'(bus.score), 1);
    bus.frame_tick = 1'b0;
    step();
    check("wrap_pass_lo", 32'(bus.pass_pulse), 0);

    // Ramp the speed up through the cap; I wraps 4->0 along the way.
    budget = 20000;
    while (m_score < 26 && budget > 0) begin
      tick();
      budget--;
    end
    check("ramp_reached", 32'(bus.score >= 10'd26), 1);

    // Collision coincident with a frame tick: stop, no advance.
    bus.collide    = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.collide    = 1'b0;
    bus.frame_tick = 1'b0;
    check("collide_q_stop", 32'(bus.Q_Stop), 1);
    repeat (5) tick();

    // Start held across STOP->INITIAL must not chain into COUNT.
    bus.Start = 1'b1;
    repeat (4) step();
    check("restart_q_initial", 32'(bus.Q_Initial), 1);
    check("restart_score", 32'(bus.score), 0);
    bus.Start = 1'b0;
    step();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;

    budget = 500;
    while (m_off != 37 && budget > 0) begin
      tick();
      budget--;
    end
    check("off37_xedge0", 32'(bus.XEdge0), 123);
    reset          = 1'b1;
    bus.frame_tick = 1'b1;
    bus.collide    = 1'b1;
    step();
    check("midrst_q_initial", 32'(bus.Q_Initial), 1);
    check("midrst_xedge1", 32'(bus.XEdge1), 320);
    reset          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.collide    = 1'b0;
    step();

    // Random phase.
    for (int n = 0; n < 6000; n++) begin
      reset          = ($urandom_range(0, 999) < 2);
      bus.collide    = ($urandom_range(0, 299) == 0);
      bus.frame_tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) bus.Start = ~bus.Start;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
